grevshfl_iter: RTL and testbench
================================

GREVSHFL_ITER -- requirements
Module: grevshfl_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only; L = log2(XLEN).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept request.
REQ-006 SHALL have port in_op  input  2  00 GREV, 01 SHFL, 10 UNSHFL, 11 reserved.
REQ-007 SHALL have port in_rs1  input  XLEN  source data.
REQ-008 SHALL have port in_rs2  input  XLEN  control operand.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_rd  output  XLEN  result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state == IDLE).
REQ-014 SHALL accept on in_valid && in_ready edge: work reg <= in_rs1, latch in_op and control, stage counter <= 0, state <= RUN.
REQ-015 SHALL apply exactly one butterfly stage per RUN cycle, counter 0..L-1; after edge with counter L-1, state <= DONE and out_rd <= work result.
REQ-016 SHALL give fixed latency of L edges from accept edge to out_valid rising, for every op and control value.
REQ-017 GREV: control c = rs2[L-1:0]; counter step j applies stage k=j, swapping adjacent 2^k-bit blocks, iff c[k]=1.
REQ-018 SHFL: control c = rs2[L-2:0]; step j (j<L-1) applies shuffle stage k=L-2-j iff c[k]=1; shuffle stage k swaps the two middle 2^k-bit quarters of every 2^(k+2)-bit group; step L-1 is a no-op.
REQ-019 UNSHFL: as SHFL but step j (j<L-1) uses k=j (ascending); step L-1 no-op.
REQ-020 SHALL ignore rs2 bits above the control field for all ops.
REQ-021 Op 11 SHALL execute as GREV with c=0 (out_rd = rs1), same latency.
REQ-022 out_valid = (state == DONE); DONE SHALL hold, out_rd stable, until out_valid && out_ready edge, then IDLE.
REQ-023 SHALL not accept a new request in RUN or DONE; in_valid ignored there; no overlap of consecutive ops (min L+2 cycles per op).
REQ-024 out_rd SHALL change only on DONE entry; it holds the last result in IDLE and RUN.
REQ-025 Inputs SHALL be sampled only on the accept edge; later changes to in_rs1/in_rs2/in_op have no effect.

Reset
REQ-026 resetn low at an edge SHALL force state IDLE, counter 0, work reg 0, out_rd 0, out_valid 0, busy 0, in_ready 1 on the next cycle.
REQ-027 Reset in RUN or DONE SHALL discard the operation; no out_valid is produced for it.
REQ-028 in_valid during a reset cycle SHALL not be accepted.

Configuration
REQ-029 Macro GREVSHFL_SHFL_EN defined: SHFL/UNSHFL implemented per REQ-018/019.
REQ-030 Macro undefined: no shuffle datapath; ops 01/10 SHALL complete with out_rd = 0 and identical latency and handshake; GREV and op 11 unchanged.

Verification
REQ-031 XLEN=32, GREV rs1=0x12345678 rs2=0x1F -> out_rd=0x1E6A2C48, out_valid exactly 5 edges after accept.
REQ-032 XLEN=32, GREV rs1=0x12345678 rs2=0xFFFFFF18 -> out_rd=0x78563412 (upper rs2 bits ignored).
REQ-033 XLEN=32, macro on: SHFL rs1=0x0000FFFF rs2=0xF -> 0x55555555; UNSHFL rs1=0x55555555 rs2=0xF -> 0x0000FFFF; macro off: both -> 0x00000000.
REQ-034 out_ready low 6 cycles in DONE -> out_valid stays 1, out_rd stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-035 resetn low for 1 cycle at RUN counter 2 -> IDLE, out_valid never asserted, out_rd=0; next request completes normally.
REQ-036 XLEN=64, GREV rs1=0x1 rs2=0x3F -> out_rd=0x8000000000000000 after 6 edges.

Source files
------------

// File: rtl/grevshfl_iter_if.sv
// Request/response bundle for the iterative GREV/SHFL unit.
// The slave modport is the unit's view and the master modport is the requester's view.
interface grevshfl_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rd;
    logic            busy;

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_rs1,
        input  in_rs2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_rd,
        output busy
    );

    modport master (
        output in_valid,
        output in_op,
        output in_rs1,
        output in_rs2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_rd,
        input  busy
    );
endinterface

// File: rtl/grevshfl_iter.sv
// Iterative generalized-reverse / shuffle unit: one butterfly stage per cycle.
// The unit accepts a request in IDLE, runs for L = log2(XLEN) cycles, and then
// holds the result in DONE until the consumer takes it.
// Optional feature macro: GREVSHFL_SHFL_EN. When it is defined, SHFL and UNSHFL
// are implemented. When it is undefined, there is no shuffle datapath, and
// ops 01/10 complete with a zero result using the same latency and handshake.
module grevshfl_iter #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           resetn,
    grevshfl_iter_if.slave bus
);
    localparam int L  = $clog2(XLEN);
    localparam int CW = $clog2(L);
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    localparam logic [1:0] OP_GREV   = 2'b00;
    localparam logic [1:0] OP_SHFL   = 2'b01;
    localparam logic [1:0] OP_UNSHFL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("grevshfl_iter: XLEN must be 32 or 64");
        end
    endgenerate

    // Bit i is set when block number (i / blk), taken modulo per, equals pos.
    function automatic logic [XLEN-1:0] block_mask(input int blk, input int per, input int pos);
        logic [XLEN-1:0] m;
        m = '0;
        for (int i = 0; i < XLEN; i++) begin
            m[i] = (((i / blk) % per) == pos);
        end
        return m;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [1:0]      op_q, op_d;
    logic [L-1:0]    ctrl_q, ctrl_d;
    logic [XLEN-1:0] rd_q, rd_d;

    logic [XLEN-1:0] stage_out;
    logic [XLEN-1:0] grev_res [L];

    // The control operand's bits above the largest control field never matter.
    logic unused_rs2_hi;
    assign unused_rs2_hi = ^bus.in_rs2[XLEN-1:L];

    // GREV stage gi swaps adjacent 2^gi-bit blocks of the working value.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_grev
            localparam int BLK = 2 ** gi;
            localparam logic [XLEN-1:0] LO = block_mask(BLK, 2, 0);
            assign grev_res[gi] = ((work_q & LO) << BLK) | ((work_q >> BLK) & LO);
        end
    endgenerate

`ifdef GREVSHFL_SHFL_EN
    logic [XLEN-1:0] shfl_res [L];
    logic [CW-1:0]   k_shfl;

    // Shuffle stage gi swaps the two middle 2^gi-bit quarters of each 2^(gi+2)-bit group.
    generate
        for (gi = 0; gi < L - 1; gi++) begin : g_shfl
            localparam int BLK = 2 ** gi;
            localparam logic [XLEN-1:0] MR = block_mask(BLK, 4, 1);
            localparam logic [XLEN-1:0] ML = block_mask(BLK, 4, 2);
            assign shfl_res[gi] = (work_q & ~(ML | MR))
                                | ((work_q << BLK) & ML)
                                | ((work_q >> BLK) & MR);
        end
    endgenerate
    // The last step of a shuffle is a pass-through, so the latency matches GREV.
    assign shfl_res[L-1] = work_q;
    // SHFL walks its stages from the highest down to the lowest.
    assign k_shfl = CW'(L - 2) - cnt_q;
`endif

    // Apply the single butterfly stage that the current step selects.
    always_comb begin
        stage_out = work_q;
        case (op_q)
            OP_GREV: begin
                if (ctrl_q[cnt_q]) begin
                    stage_out = grev_res[cnt_q];
                end
            end
`ifdef GREVSHFL_SHFL_EN
            OP_SHFL: begin
                if (cnt_q != LAST) begin
                    if (ctrl_q[k_shfl]) begin
                        stage_out = shfl_res[k_shfl];
                    end
                end
            end
            OP_UNSHFL: begin
                if (cnt_q != LAST) begin
                    if (ctrl_q[cnt_q]) begin
                        stage_out = shfl_res[cnt_q];
                    end
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Next-state logic: accept in IDLE, step through RUN, and hold in DONE until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        op_d    = op_q;
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    work_d  = bus.in_rs1;
                    case (bus.in_op)
                        OP_GREV: begin
                            op_d   = OP_GREV;
                            ctrl_d = bus.in_rs2[L-1:0];
                        end
`ifdef GREVSHFL_SHFL_EN
                        OP_SHFL, OP_UNSHFL: begin
                            op_d   = bus.in_op;
                            ctrl_d = {1'b0, bus.in_rs2[L-2:0]};
                        end
`else
                        // With no shuffle hardware, run an identity GREV on zero instead.
                        OP_SHFL, OP_UNSHFL: begin
                            op_d   = OP_GREV;
                            ctrl_d = '0;
                            work_d = '0;
                        end
`endif
                        // The reserved op behaves as an identity GREV.
                        default: begin
                            op_d   = OP_GREV;
                            ctrl_d = '0;
                        end
                    endcase
                end
            end
            RUN: begin
                work_d = stage_out;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    rd_d    = stage_out;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; a low resetn drops any operation that is in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            op_q    <= OP_GREV;
            ctrl_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_rd    = rd_q;
endmodule

// File: tb/tb_grevshfl_iter.sv
// Directed bench for grevshfl_iter: one 32-bit and one 64-bit instance.
// The shuffle expectations follow GREVSHFL_SHFL_EN.
module tb_grevshfl_iter;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    grevshfl_iter_if #(.XLEN(32)) bus32();
    grevshfl_iter_if #(.XLEN(64)) bus64();

    grevshfl_iter #(.XLEN(32)) dut32 (.clk(clk), .resetn(resetn), .bus(bus32));
    grevshfl_iter #(.XLEN(64)) dut64 (.clk(clk), .resetn(resetn), .bus(bus64));

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rd;

`ifdef GREVSHFL_SHFL_EN
    localparam bit SHFL_ON = 1'b1;
`else
    localparam bit SHFL_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one full 32-bit transaction, then scramble the inputs right after acceptance.
    task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] exp);
        int edges;
        bus32.in_op    = op;
        bus32.in_rs1   = rs1;
        bus32.in_rs2   = rs2;
        bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        bus32.in_op    = ~op;
        bus32.in_rs1   = ~rs1;
        bus32.in_rs2   = ~rs2;
        check({tag, "_busy"}, 64'(bus32.busy), 64'd1);
        check({tag, "_hold"}, 64'(bus32.out_rd), 64'(last_rd));
        edges = 0;
        while (!bus32.out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check({tag, "_lat"}, 64'(edges), 64'd5);
        check({tag, "_rd"}, 64'(bus32.out_rd), 64'(exp));
        $display("txn %s op=%0d rs1=%h rs2=%h rd=%h lat=%0d", tag, op, rs1, rs2, bus32.out_rd, edges);
        bus32.out_ready = 1'b1;
        tick();
        bus32.out_ready = 1'b0;
        check({tag, "_idle"}, 64'(bus32.in_ready), 64'd1);
        last_rd = exp;
    endtask

    initial begin
        int edges;
        logic seen_valid;

        resetn          = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.in_op     = 2'b00;
        bus32.in_rs1    = '0;
        bus32.in_rs2    = '0;
        bus32.out_ready = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_op     = 2'b00;
        bus64.in_rs1    = '0;
        bus64.in_rs2    = '0;
        bus64.out_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;

        check("rst_rd", 64'(bus32.out_rd), 64'd0);
        check("rst_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_ready", 64'(bus32.in_ready), 64'd1);
        last_rd = 32'h0;

        run32("grev_rev",   2'b00, 32'h12345678, 32'h0000001F, 32'h1E6A2C48);
        run32("grev_bswap", 2'b00, 32'h12345678, 32'hFFFFFF18, 32'h78563412);
        run32("grev_bit",   2'b00, 32'h12345678, 32'h00000001, 32'h2138A9B4);
        run32("grev_half",  2'b00, 32'h12345678, 32'h00000010, 32'h56781234);
        run32("op11",       2'b11, 32'hDEADBEEF, 32'h0000001F, 32'hDEADBEEF);
        run32("shfl_full",  2'b01, 32'h0000FFFF, 32'h0000000F, SHFL_ON ? 32'h55555555 : 32'h0);
        run32("unshfl_full",2'b10, 32'h55555555, 32'h0000000F, SHFL_ON ? 32'h0000FFFF : 32'h0);
        run32("shfl_hi",    2'b01, 32'h12345678, 32'h00000018, SHFL_ON ? 32'h12563478 : 32'h0);
        run32("unshfl_hi",  2'b10, 32'h12563478, 32'h00000008, SHFL_ON ? 32'h12345678 : 32'h0);

        // DONE holds while out_ready stays low, and in_valid pulses are ignored.
        bus32.in_op    = 2'b00;
        bus32.in_rs1   = 32'h12345678;
        bus32.in_rs2   = 32'h00000008;
        bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        edges = 0;
        while (!bus32.out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check("stall_lat", 64'(edges), 64'd5);
        check("stall_rd", 64'(bus32.out_rd), 64'h34127856);
        for (int i = 0; i < 6; i++) begin
            bus32.in_valid = (i % 2) == 0;
            bus32.in_rs1   = 32'hA5A5_0000 + 32'(i);
            tick();
            check("stall_valid", 64'(bus32.out_valid), 64'd1);
            check("stall_hold", 64'(bus32.out_rd), 64'h34127856);
            check("stall_ready", 64'(bus32.in_ready), 64'd0);
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        tick();
        bus32.out_ready = 1'b0;
        check("stall_release_valid", 64'(bus32.out_valid), 64'd0);
        check("stall_release_ready", 64'(bus32.in_ready), 64'd1);
        tick();
        check("stall_no_accept", 64'(bus32.busy), 64'd0);
        $display("txn stall rd=34127856 held 6 cycles");
        last_rd = 32'h34127856;

        // A reset at RUN counter 2 discards the operation, even with in_valid high.
        bus32.in_op    = 2'b00;
        bus32.in_rs1   = 32'h12345678;
        bus32.in_rs2   = 32'h0000001F;
        bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        tick();
        tick();
        resetn         = 1'b0;
        bus32.in_valid = 1'b1;
        tick();
        resetn         = 1'b1;
        bus32.in_valid = 1'b0;
        check("mrst_busy", 64'(bus32.busy), 64'd0);
        check("mrst_ready", 64'(bus32.in_ready), 64'd1);
        check("mrst_valid", 64'(bus32.out_valid), 64'd0);
        check("mrst_rd", 64'(bus32.out_rd), 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_valid = seen_valid | bus32.out_valid;
        end
        check("mrst_no_valid", 64'(seen_valid), 64'd0);
        check("mrst_still_idle", 64'(bus32.busy), 64'd0);
        $display("txn midrun_reset discarded");
        last_rd = 32'h0;
        run32("after_rst", 2'b00, 32'h12345678, 32'h0000001F, 32'h1E6A2C48);

        // 64-bit instance: a full bit reverse takes six stages.
        bus64.in_op    = 2'b00;
        bus64.in_rs1   = 64'h1;
        bus64.in_rs2   = 64'h3F;
        bus64.in_valid = 1'b1;
        tick();
        bus64.in_valid = 1'b0;
        bus64.in_rs1   = 64'hFFFF;
        edges = 0;
        while (!bus64.out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check("x64_lat", 64'(edges), 64'd6);
        check("x64_rd", bus64.out_rd, 64'h8000000000000000);
        $display("txn x64 op=0 rs1=1 rs2=3f rd=%h lat=%0d", bus64.out_rd, edges);
        bus64.out_ready = 1'b1;
        tick();
        bus64.out_ready = 1'b0;
        check("x64_idle", 64'(bus64.in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
